// File: rtl/strv32i_pkg.sv
// Shared types and constants for the STRV32I fetch stage.
package strv32i_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    function automatic logic addr_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC select (trap > redirect > PC+4 > hold) with target alignment check.
// Behaviour depends on STRV32I_ALIGN_CHECK_EN.
module fetch_pc_sel
    import strv32i_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        trap,
    input  logic [31:0] trap_addr,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        advance,
    output logic [31:0] next_pc,
    output logic        take_redirect,
    output logic        target_misaligned
);

    logic [31:0] target_s;
    logic [31:0] target_fixed_s;

    // Pick the redirect source and the resulting next PC.
    always_comb begin
        target_s      = redirect_addr;
        take_redirect = 1'b0;
        if (trap) begin
            target_s      = trap_addr;
            take_redirect = 1'b1;
        end else if (redirect) begin
            target_s      = redirect_addr;
            take_redirect = 1'b1;
        end else begin
            target_s      = redirect_addr;
            take_redirect = 1'b0;
        end

`ifdef STRV32I_ALIGN_CHECK_EN
        target_fixed_s    = target_s;
        target_misaligned = take_redirect & addr_misaligned(target_s);
`else
        // Without the check, low bits are simply dropped.
        target_fixed_s    = target_s & ~32'h0000_0003;
        target_misaligned = 1'b0;
`endif

        if (take_redirect) begin
            next_pc = target_fixed_s;
        end else if (advance) begin
            next_pc = pc + PC_INCR;
        end else begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// STRV32I fetch stage: PC, single-outstanding imem requests, instruction register.
// Optional misaligned-target fault enabled by STRV32I_ALIGN_CHECK_EN.
module instr_fetch_unit
    import strv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_addr_in,
    input  logic        trap_in,
    input  logic [31:0] trap_addr_in,
    input  logic        stall_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    output logic        misaligned_out
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic [31:0]  instr_r;
    logic [31:0]  pc_out_r;
    logic         valid_r;
    logic [31:0]  next_pc_s;
    logic         take_s;
    logic         target_mis_s;
    logic         advance_s;
    logic         redirect_gate_s;
    logic         outstanding_s;
`ifdef STRV32I_ALIGN_CHECK_EN
    logic         mis_r;
    logic         pending_r;
`endif

    assign advance_s       = (state_r == WAIT) & imem_rvalid_in;
    // Only a trap may leave FAULT; plain redirects are ignored there.
    assign redirect_gate_s = redirect_in & (state_r != FAULT);

    fetch_pc_sel u_pc_sel (
        .pc                (pc_r),
        .trap              (trap_in),
        .trap_addr         (trap_addr_in),
        .redirect          (redirect_gate_s),
        .redirect_addr     (redirect_addr_in),
        .advance           (advance_s),
        .next_pc           (next_pc_s),
        .take_redirect     (take_s),
        .target_misaligned (target_mis_s)
    );

    // Whether a response will still be owed after this cycle if we redirect now.
    always_comb begin
        outstanding_s = 1'b0;
        case (state_r)
            FETCH:       outstanding_s = imem_gnt_in;
            WAIT, DRAIN: outstanding_s = ~imem_rvalid_in;
`ifdef STRV32I_ALIGN_CHECK_EN
            FAULT:       outstanding_s = pending_r & ~imem_rvalid_in;
`endif
            default:     outstanding_s = 1'b0;
        endcase
    end

    // Fetch FSM, PC and instruction register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r  <= FETCH;
            pc_r     <= RESET_PC;
            instr_r  <= NOP_INSTR;
            pc_out_r <= RESET_PC;
            valid_r  <= 1'b0;
`ifdef STRV32I_ALIGN_CHECK_EN
            mis_r     <= 1'b0;
            pending_r <= 1'b0;
`endif
        end else begin
            pc_r <= next_pc_s;
            if (take_s) begin
                valid_r <= 1'b0;
`ifdef STRV32I_ALIGN_CHECK_EN
                if (target_mis_s) begin
                    state_r   <= FAULT;
                    mis_r     <= 1'b1;
                    pending_r <= outstanding_s;
                end else begin
                    state_r   <= outstanding_s ? DRAIN : FETCH;
                    mis_r     <= 1'b0;
                    pending_r <= 1'b0;
                end
`else
                state_r <= (outstanding_s & ~target_mis_s) ? DRAIN : FETCH;
`endif
            end else begin
                case (state_r)
                    FETCH: begin
                        if (imem_gnt_in) state_r <= WAIT;
                        else             state_r <= FETCH;
                    end
                    WAIT: begin
                        if (imem_rvalid_in) begin
                            instr_r  <= imem_rdata_in;
                            pc_out_r <= pc_r;
                            valid_r  <= 1'b1;
                            state_r  <= HOLD;
                        end else begin
                            state_r  <= WAIT;
                        end
                    end
                    HOLD: begin
                        if (!stall_in) begin
                            valid_r <= 1'b0;
                            state_r <= FETCH;
                        end else begin
                            state_r <= HOLD;
                        end
                    end
                    DRAIN: begin
                        if (imem_rvalid_in) state_r <= FETCH;
                        else                state_r <= DRAIN;
                    end
`ifdef STRV32I_ALIGN_CHECK_EN
                    FAULT: begin
                        if (imem_rvalid_in) pending_r <= 1'b0;
                        else                pending_r <= pending_r;
                        state_r <= FAULT;
                    end
`endif
                    default: state_r <= FETCH;
                endcase
            end
        end
    end

    assign imem_req_out    = (state_r == FETCH) & ~rst_in;
    assign imem_addr_out   = pc_r;
    assign instr_out       = instr_r;
    assign pc_out          = pc_out_r;
    assign instr_valid_out = valid_r;
`ifdef STRV32I_ALIGN_CHECK_EN
    assign misaligned_out  = mis_r;
`else
    assign misaligned_out  = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the STRV32I core, directly upstream of the decoder. Holds the program counter, issues single-outstanding requests to instruction memory, and captures the returned word into an instruction register. Presents `instr_out`/`pc_out` with a valid/stall handshake; the decoder consumes `instr_out[14:12]`, `instr_out[6:2]` and `instr_out[30]`. Applies branch/jump redirects and trap redirects, and discards any in-flight response made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk_in` input 1: single clock; all state updates on rising edge.
- `rst_in` input 1: synchronous reset, active-high.
- `redirect_in` input 1: taken branch/jump this cycle.
- `redirect_addr_in` input 32: branch/jump target.
- `trap_in` input 1: trap/interrupt entry; priority over `redirect_in`.
- `trap_addr_in` input 32: trap vector.
- `stall_in` input 1: downstream cannot accept the presented instruction.
- `imem_req_out` output 1: fetch request valid.
- `imem_addr_out` output 32: fetch address, always equal to the current PC.
- `imem_gnt_in` input 1: memory accepted the request this cycle.
- `imem_rvalid_in` input 1: response data valid.
- `imem_rdata_in` input 32: instruction word.
- `instr_out` output 32: captured instruction.
- `pc_out` output 32: PC of `instr_out`.
- `instr_valid_out` output 1: `instr_out` is valid.
- `misaligned_out` output 1: fetch-address misaligned fault (see Configuration).

## Operation
- **States**
  - FETCH: `imem_req_out`=1. Goes to WAIT on `imem_gnt_in`.
  - WAIT: waits for `imem_rvalid_in`. On rvalid, captures rdata into `instr_out` and the PC into `pc_out`, sets `instr_valid_out`, PC <= PC+4, then goes to HOLD.
  - HOLD: presents the instruction. When `stall_in`=0 the instruction is consumed: `instr_valid_out` clears and the block goes to FETCH. When `stall_in`=1 all outputs hold.
  - DRAIN: waits for the stale response. On rvalid, discards it and goes to FETCH.
  - FAULT: only reachable with the macro defined.
- **Redirect** (`trap_in` or `redirect_in`, with `trap_in` winning):
  - PC <= target and `instr_valid_out` <= 0, in any state.
  - From FETCH with `imem_gnt_in`=1 in the same cycle, or from WAIT: go to DRAIN. The old-address request is already issued.
  - From FETCH without gnt: stay in FETCH. The address changes on the next cycle while req stays high. The memory tolerates address change while ungranted.
  - From HOLD or DRAIN: go to FETCH, or stay in DRAIN if a response is still outstanding.
  - A redirect in the same cycle as rvalid in WAIT discards that response, with no capture.
- **Arithmetic:** PC+4 wraps modulo 2^32.
- At most one request is outstanding at any time.
- **Reset values:**
  - State = FETCH, PC = `RESET_PC`.
  - `imem_req_out`=0 while `rst_in`=1.
  - `imem_addr_out`=`RESET_PC`.
  - `instr_out`=32'h0000_0013 (NOP).
  - `pc_out`=`RESET_PC`.
  - `instr_valid_out`=0, `misaligned_out`=0.
- **Reset mid-transaction:** abandons any outstanding request. The memory side is reset by the same `rst_in`.

## Timing
- `imem_req_out` is combinational from state. All other outputs are registered.
- Zero-wait memory (gnt in the request cycle, rvalid one cycle later):
  - Cycle 0 FETCH, cycle 1 WAIT with rvalid, cycle 2 HOLD with `instr_valid_out`=1.
  - Sustained throughput is one instruction per 3 cycles.
- Redirect latency: `imem_addr_out` shows the target on the cycle after `redirect_in`. When DRAIN is not needed, req is high that same cycle.
- `imem_gnt_in` and `imem_rvalid_in` are ignored in states where they are not expected.

## Configuration
- `STRV32I_ALIGN_CHECK_EN` defined:
  - A redirect/trap target with `[1:0]`!=0 loads the PC, sets `misaligned_out`=1 (registered), issues no request and enters FAULT.
  - FAULT remains until the next `trap_in`, which clears `misaligned_out` and resumes normally.
  - A pending stale response is still drained before FETCH.
- `STRV32I_ALIGN_CHECK_EN` undefined:
  - Target bits `[1:0]` are forced to 00.
  - `misaligned_out` is tied 0.
  - FAULT state is absent.

## Structure
- Shared package `strv32i_pkg`:
  - Fetch state enum (FETCH, WAIT, HOLD, DRAIN, FAULT).
  - `NOP_INSTR` = 32'h0000_0013.
  - `PC_INCR` = 4.
- One sub-module, `fetch_pc_sel`: combinational next-PC select (trap > redirect > PC+4 > hold) plus the alignment check.
- FSM and registers live in `instr_fetch_unit`.

## Test plan
- Reset, `RESET_PC`=32'h100, zero-wait memory returning 32'h00500093: first req at addr 32'h100; `instr_valid_out`=1 with `instr_out`=32'h00500093 and `pc_out`=32'h100 two cycles after gnt; next req at 32'h104.
- `stall_in` high for 4 cycles in HOLD: `instr_out`, `pc_out` and `instr_valid_out` stable; no `imem_req_out`; resume fetches 32'h108.
- `redirect_in` to 32'h200 in WAIT, response arriving 3 cycles later: response discarded; `instr_valid_out` stays 0; next req at 32'h200.
- `trap_in` (32'h80) and `redirect_in` (32'h300) in the same cycle: next request at 32'h80.
- PC 32'hFFFF_FFFC fetch completes: next request address is 32'h0000_0000.
- Macro on, redirect to 32'h202: `misaligned_out`=1, no req; after `trap_in` to 32'h40, `misaligned_out`=0 and req at 32'h40. Macro off, same redirect: req at 32'h200.
